read_channel_router: RTL
========================

Name: read_channel_router

Overview:
- Sits directly downstream of the AXI read arbiter.
- Takes the arbiter's decoded grant (master index, slave index), then routes one complete AR + R burst between that master and that slave.
- Drives the granted master's AR onto the selected slave, returns R beats to that master until the RLAST handshake, then pulses `rd_done` so the arbiter returns to IDLE.
- Unmapped addresses are served by an internal default slave that returns DECERR.

Parameters:
- NUM_M, 3, number of masters (M0..M2).
- NUM_S, 8, number of slaves (S0..S7); grant slave index NUM_S selects the internal default slave.
- ADDR_W, 32, address/data width.
- IDM_W, 4, master-side ID width; slave-side ID width = IDM_W+4.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous, active-high reset.
- grant_vld  in  1  arbiter grant valid.
- grant_m  in  2  granted master index.
- grant_s  in  4  granted slave index; value NUM_S = no slave.
- ARID_M / ARADDR_M / ARLEN_M / ARSIZE_M / ARBURST_M  in  NUM_M*{IDM_W,32,4,3,2}  packed per-master AR payload.
- ARVALID_M  in  NUM_M;  ARREADY_M  out  NUM_M.
- RID_M / RDATA_M / RRESP_M / RLAST_M / RVALID_M  out  NUM_M*{IDM_W,32,2,1,1}.
- RREADY_M  in  NUM_M.
- ARID_S / ARADDR_S / ARLEN_S / ARSIZE_S / ARBURST_S / ARVALID_S  out  NUM_S*{IDM_W+4,32,4,3,2,1}.
- ARREADY_S  in  NUM_S.
- RID_S / RDATA_S / RRESP_S / RLAST_S / RVALID_S  in  NUM_S*{IDM_W+4,32,2,1,1}.
- RREADY_S  out  NUM_S.
- rd_done  out  1  one-cycle pulse on final R handshake.
- beat_err  out  1  sticky: slave RLAST disagreed with ARLEN.

Behaviour:
- Reset (ARESET=1 at ACLK edge):
  - state=IDLE; all ARVALID_S, ARREADY_M, RVALID_M, RREADY_S, rd_done, beat_err = 0; latched m/s/len/count = 0.
  - Reset mid-burst abandons the burst with no rd_done.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE:
  - If grant_vld, latch grant_m and grant_s.
  - Go to ADDR if grant_s<NUM_S, else ERR.
  - ERR entry also completes the master's AR handshake that cycle: ARREADY_M[m]=1 and ARLEN latched.
- ADDR:
  - Combinational pass-through: ARVALID_S[s]=ARVALID_M[m] and ARREADY_M[m]=ARREADY_S[s].
  - Payload copied; ARID_S[s] = {4'(m), ARID_M[m]}.
  - On ARVALID&&ARREADY: latch ARLEN, clear beat count, go to DATA.
  - Non-selected channels stay 0.
- DATA:
  - RVALID_M[m]=RVALID_S[s] and RREADY_S[s]=RREADY_M[m].
  - RID_M[m] = RID_S[s][IDM_W-1:0]; upper ID bits are ignored.
  - Count increments on each handshake.
  - On a handshake with RLAST_S[s]=1: rd_done=1 next cycle, go to IDLE.
  - If RLAST arrives with count≠ARLEN, or count reaches ARLEN without RLAST, set beat_err.
  - Routing always ends on the slave's RLAST, never on the count.
- ERR (default slave):
  - Drives ARLEN+1 beats: RVALID_M[m]=1, RDATA=0, RRESP=2'b11 (DECERR), RID=latched ARID.
  - RLAST=1 on the beat where count==ARLEN.
  - Count advances only on RREADY_M[m]; RVALID holds while RREADY=0.
  - After the final beat: rd_done pulse, go to IDLE.
- Latency:
  - Grant to slave ARVALID: 1 cycle.
  - Last R handshake to rd_done: 1 cycle.
  - IDLE re-accepts a grant in the rd_done cycle.
- A grant_vld arriving while not in IDLE is ignored.
- Count is 4 bits; ARLEN=15 gives 16 beats with no wrap ambiguity.

Test Plan:
- Basic read:
  - Stimulus: grant m=0, s=1; ARADDR=0x0001_0040, ARLEN=3, ARID=0x5; slave ARREADY after 2 cycles.
  - Required response: ARID_S[1]=0x05; 4 beats routed to M0 with RID=0x5; RLAST on beat 4; rd_done 1 cycle later; beat_err=0.
- Backpressure:
  - Stimulus: same burst with RREADY_M0 toggling every cycle.
  - Required response: RREADY_S1 mirrors it; no beat lost or duplicated; 4 handshakes total.
- Decode error:
  - Stimulus: grant m=1, s=8, ARLEN=1.
  - Required response: ARREADY_M1 pulse; 2 beats RDATA=0, RRESP=2'b11, RLAST on beat 2; no ARVALID_S asserted.
- Protocol check:
  - Stimulus: slave asserts RLAST on beat 2 of an ARLEN=3 burst.
  - Required response: burst ends and rd_done fires; beat_err=1 and stays set until ARESET.
- Reset mid-burst:
  - Stimulus: ARESET during DATA beat 2 (M2 to S5).
  - Required response: next cycle all valids/readys=0, state IDLE; a new grant is accepted normally.
- Back-to-back:
  - Stimulus: grant_vld held with new m=2, s=3 in the rd_done cycle.
  - Required response: ARVALID_S[3] asserted on the following cycle.

Source files
------------

// File: rtl/read_channel_router.sv
// -----------------------------------------------------------------------------
// read_channel_router
//   Routes one complete AXI read burst (AR + all R beats) between the master
//   and slave picked by the upstream read arbiter. A grant slave index of NUM_S
//   (or above) selects an internal default slave that answers with DECERR.
//
// Ports
//   ACLK, ARESET             clock, synchronous active-high reset
//   grant_vld/_m/_s          decoded arbiter grant (master, slave index)
//   AR*_M, ARVALID_M/ARREADY_M   per-master AR channels (packed, NUM_M wide)
//   R*_M, RVALID_M/RREADY_M      per-master R channels
//   AR*_S, ARVALID_S/ARREADY_S   per-slave AR channels (ID widened by 4 bits)
//   R*_S, RVALID_S/RREADY_S      per-slave R channels
//   rd_done                  one-cycle pulse after the final R handshake
//   beat_err                 sticky: slave RLAST disagreed with ARLEN
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for grant_vld; latches master/slave indices
// ADDR  | AR pass-through from granted master to selected slave
// DATA  | R pass-through from slave back to master until RLAST
// ERR   | default slave: ARLEN+1 DECERR beats generated internally
// -----------------------------------------------------------------------------
module read_channel_router #(
  parameter int NUM_M  = 3,
  parameter int NUM_S  = 8,
  parameter int ADDR_W = 32,
  parameter int IDM_W  = 4,
  localparam int IDS_W = IDM_W + 4
) (
  input  logic                      ACLK,
  input  logic                      ARESET,

  input  logic                      grant_vld,
  input  logic [1:0]                grant_m,
  input  logic [3:0]                grant_s,

  input  logic [NUM_M*IDM_W-1:0]    ARID_M,
  input  logic [NUM_M*ADDR_W-1:0]   ARADDR_M,
  input  logic [NUM_M*4-1:0]        ARLEN_M,
  input  logic [NUM_M*3-1:0]        ARSIZE_M,
  input  logic [NUM_M*2-1:0]        ARBURST_M,
  input  logic [NUM_M-1:0]          ARVALID_M,
  output logic [NUM_M-1:0]          ARREADY_M,

  output logic [NUM_M*IDM_W-1:0]    RID_M,
  output logic [NUM_M*ADDR_W-1:0]   RDATA_M,
  output logic [NUM_M*2-1:0]        RRESP_M,
  output logic [NUM_M-1:0]          RLAST_M,
  output logic [NUM_M-1:0]          RVALID_M,
  input  logic [NUM_M-1:0]          RREADY_M,

  output logic [NUM_S*IDS_W-1:0]    ARID_S,
  output logic [NUM_S*ADDR_W-1:0]   ARADDR_S,
  output logic [NUM_S*4-1:0]        ARLEN_S,
  output logic [NUM_S*3-1:0]        ARSIZE_S,
  output logic [NUM_S*2-1:0]        ARBURST_S,
  output logic [NUM_S-1:0]          ARVALID_S,
  input  logic [NUM_S-1:0]          ARREADY_S,

  input  logic [NUM_S*IDS_W-1:0]    RID_S,
  input  logic [NUM_S*ADDR_W-1:0]   RDATA_S,
  input  logic [NUM_S*2-1:0]        RRESP_S,
  input  logic [NUM_S-1:0]          RLAST_S,
  input  logic [NUM_S-1:0]          RVALID_S,
  output logic [NUM_S-1:0]          RREADY_S,

  output logic                      rd_done,
  output logic                      beat_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        m_q, m_d;
  logic [3:0]        s_q, s_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDM_W-1:0]  id_q, id_d;
  logic              rd_done_q, rd_done_d;
  logic              beat_err_q, beat_err_d;

  // Channel of the latched master
  logic [IDM_W-1:0]  sel_arid_m;
  logic [ADDR_W-1:0] sel_araddr_m;
  logic [3:0]        sel_arlen_m;
  logic [2:0]        sel_arsize_m;
  logic [1:0]        sel_arburst_m;
  logic              sel_arvalid_m;
  logic              sel_rready_m;

  // AR payload of the master being granted right now (default-slave entry)
  logic [IDM_W-1:0]  gnt_arid_m;
  logic [3:0]        gnt_arlen_m;

  // Channel of the latched slave
  logic              sel_arready_s;
  logic [IDS_W-1:0]  sel_rid_s;
  logic [ADDR_W-1:0] sel_rdata_s;
  logic [1:0]        sel_rresp_s;
  logic              sel_rlast_s;
  logic              sel_rvalid_s;

  always_comb begin : master_select
    sel_arid_m    = '0;
    sel_araddr_m  = '0;
    sel_arlen_m   = '0;
    sel_arsize_m  = '0;
    sel_arburst_m = '0;
    sel_arvalid_m = 1'b0;
    sel_rready_m  = 1'b0;
    gnt_arid_m    = '0;
    gnt_arlen_m   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (m_q == 2'(i)) begin
        sel_arid_m    = ARID_M[i*IDM_W +: IDM_W];
        sel_araddr_m  = ARADDR_M[i*ADDR_W +: ADDR_W];
        sel_arlen_m   = ARLEN_M[i*4 +: 4];
        sel_arsize_m  = ARSIZE_M[i*3 +: 3];
        sel_arburst_m = ARBURST_M[i*2 +: 2];
        sel_arvalid_m = ARVALID_M[i];
        sel_rready_m  = RREADY_M[i];
      end
      if (grant_m == 2'(i)) begin
        gnt_arid_m  = ARID_M[i*IDM_W +: IDM_W];
        gnt_arlen_m = ARLEN_M[i*4 +: 4];
      end
    end
  end

  always_comb begin : slave_select
    sel_arready_s = 1'b0;
    sel_rid_s     = '0;
    sel_rdata_s   = '0;
    sel_rresp_s   = '0;
    sel_rlast_s   = 1'b0;
    sel_rvalid_s  = 1'b0;
    for (int i = 0; i < NUM_S; i++) begin
      if (s_q == 4'(i)) begin
        sel_arready_s = ARREADY_S[i];
        sel_rid_s     = RID_S[i*IDS_W +: IDS_W];
        sel_rdata_s   = RDATA_S[i*ADDR_W +: ADDR_W];
        sel_rresp_s   = RRESP_S[i*2 +: 2];
        sel_rlast_s   = RLAST_S[i];
        sel_rvalid_s  = RVALID_S[i];
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    m_d        = m_q;
    s_d        = s_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rd_done_d  = 1'b0;
    beat_err_d = beat_err_q;

    ARREADY_M = '0;
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = '0;
    RLAST_M   = '0;
    RVALID_M  = '0;
    ARID_S    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
    ARVALID_S = '0;
    RREADY_S  = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          m_d   = grant_m;
          s_d   = grant_s;
          cnt_d = '0;
          if (grant_s < 4'(NUM_S)) begin
            state_d = S_ADDR;
          end else begin
            // No real slave will answer, so the AR handshake is taken here
            // and the burst length/ID captured for the DECERR beats.
            state_d = S_ERR;
            len_d   = gnt_arlen_m;
            id_d    = gnt_arid_m;
            for (int i = 0; i < NUM_M; i++) begin
              if (grant_m == 2'(i)) ARREADY_M[i] = 1'b1;
            end
          end
        end
      end

      S_ADDR: begin
        for (int i = 0; i < NUM_S; i++) begin
          if (s_q == 4'(i)) begin
            ARVALID_S[i]                 = sel_arvalid_m;
            ARID_S[i*IDS_W +: IDS_W]     = {4'(m_q), sel_arid_m};
            ARADDR_S[i*ADDR_W +: ADDR_W] = sel_araddr_m;
            ARLEN_S[i*4 +: 4]            = sel_arlen_m;
            ARSIZE_S[i*3 +: 3]           = sel_arsize_m;
            ARBURST_S[i*2 +: 2]          = sel_arburst_m;
          end
        end
        for (int i = 0; i < NUM_M; i++) begin
          if (m_q == 2'(i)) ARREADY_M[i] = sel_arready_s;
        end
        if (sel_arvalid_m && sel_arready_s) begin
          len_d   = sel_arlen_m;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        for (int i = 0; i < NUM_S; i++) begin
          if (s_q == 4'(i)) RREADY_S[i] = sel_rready_m;
        end
        for (int i = 0; i < NUM_M; i++) begin
          if (m_q == 2'(i)) begin
            RVALID_M[i]                 = sel_rvalid_s;
            RID_M[i*IDM_W +: IDM_W]     = sel_rid_s[IDM_W-1:0];
            RDATA_M[i*ADDR_W +: ADDR_W] = sel_rdata_s;
            RRESP_M[i*2 +: 2]           = sel_rresp_s;
            RLAST_M[i]                  = sel_rlast_s;
          end
        end
        if (sel_rvalid_s && sel_rready_m) begin
          cnt_d = cnt_q + 4'd1;
          // The slave's RLAST terminates routing; the count only flags
          // disagreement with the requested length.
          if (sel_rlast_s) begin
            if (cnt_q != len_q) beat_err_d = 1'b1;
            rd_done_d = 1'b1;
            state_d   = S_IDLE;
          end else if (cnt_q == len_q) begin
            beat_err_d = 1'b1;
          end
        end
      end

      S_ERR: begin
        for (int i = 0; i < NUM_M; i++) begin
          if (m_q == 2'(i)) begin
            RVALID_M[i]             = 1'b1;
            RID_M[i*IDM_W +: IDM_W] = id_q;
            RRESP_M[i*2 +: 2]       = 2'b11;
            RLAST_M[i]              = (cnt_q == len_q);
          end
        end
        if (sel_rready_m) begin
          if (cnt_q == len_q) begin
            rd_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      s_q        <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      rd_done_q  <= 1'b0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      rd_done_q  <= rd_done_d;
      beat_err_q <= beat_err_d;
    end
  end

  assign rd_done  = rd_done_q;
  assign beat_err = beat_err_q;

endmodule
